exp5_detector_jogada: RTL and testbench

//   Conditions the raw player buttons and generates the single-cycle 'jogada' strobe plus
//   the one-hot played value consumed by the game control unit and datapath.

---
 rtl/exp5_detector_jogada.sv | 180 ++++++++++++++++++
 tb/tb_exp5_detector_jogada.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp5_detector_jogada.sv
// exp5_detector_jogada
//   Conditions the raw player push-buttons for the game control unit. The buttons pass
//   through a 2-flop synchronizer. A press must be stable for DEBOUNCE_CICLOS cycles
//   before it is recognised, and a release must also be debounced before a new press is
//   accepted. A recognised press either produces a one-cycle 'jogada' strobe with its
//   one-hot value, or a one-cycle 'ignorada' strobe. The press is ignored when more than
//   one button is held or when the control unit is not waiting.
//   Optional feature: define EXP5_TIMEOUT_EN to add an idle-timeout strobe. With the
//   macro undefined, 'timeout' is tied to 0.
module exp5_detector_jogada #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int TIMEOUT_CICLOS  = 250000000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                habilita,
   output logic                jogada,
   output logic [N_BOTOES-1:0] valor_jogada,
   output logic                ignorada,
   output logic                timeout,
   output logic [2:0]          db_estado
);

   localparam int            CW      = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

   // Reject parameter values the counters cannot represent.
   if (DEBOUNCE_CICLOS < 2) begin : g_chk_debounce
      $error("DEBOUNCE_CICLOS must be at least 2");
   end
   if (TIMEOUT_CICLOS < 2) begin : g_chk_timeout
      $error("TIMEOUT_CICLOS must be at least 2");
   end

   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      FILTRA        = 3'd1,
      PULSO         = 3'd2,
      DESCARTA      = 3'd3,
      ESPERA_SOLTAR = 3'd4
   } estado_t;

   estado_t             estado, prox_estado;
   logic [N_BOTOES-1:0] sinc1, s, cap;
   logic [CW-1:0]       cnt;
   logic                cnt_zera, cnt_inc, cap_carrega, valor_carrega;
   logic                cap_um_quente;

   // The captured value is accepted only when exactly one bit is set.
   assign cap_um_quente = (cap != '0) && ((cap & (cap - N_BOTOES'(1))) == '0);

   // Two-flop synchronizer for the asynchronous buttons.
   always_ff @(posedge clock) begin
      // NOTE: sequential state always uses non-blocking assignments, so every flop
      // samples the values from before the edge, whatever order the blocks run in.
      if (reset) begin
         sinc1 <= '0;
         s     <= '0;
      end else begin
         sinc1 <= botoes;
         s     <= sinc1;
      end
   end

   // State register, debounce counter, capture and output value registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         // Reset goes to ESPERA_SOLTAR so that a button held through reset must be
         // released before it can count as a press.
         estado       <= ESPERA_SOLTAR;
         cnt          <= '0;
         cap          <= '0;
         valor_jogada <= '0;
      end else begin
         estado <= prox_estado;
         if (cnt_zera)
            cnt <= '0;
         else if (cnt_inc)
            cnt <= cnt + CW'(1);
         if (cap_carrega)
            cap <= s;
         // Loaded on the edge into PULSO, so the value appears together with jogada.
         if (valor_carrega)
            valor_jogada <= cap;
      end
   end

   // Next-state logic and datapath controls.
   always_comb begin
      // NOTE: every signal gets a default before the case statement, so no path can
      // leave one unassigned and infer a latch.
      prox_estado   = estado;
      cnt_zera      = 1'b0;
      cnt_inc       = 1'b0;
      cap_carrega   = 1'b0;
      valor_carrega = 1'b0;
      case (estado)
         OCIOSO: begin
            if (s != '0) begin
               prox_estado = FILTRA;
               cap_carrega = 1'b1;
               cnt_zera    = 1'b1;
            end
         end
         FILTRA: begin
            if (s == '0) begin
               prox_estado = OCIOSO;
            end else if (s != cap) begin
               // A bounce or a change of buttons restarts the stability window.
               cap_carrega = 1'b1;
               cnt_zera    = 1'b1;
            end else if (cnt == CNT_FIM) begin
               // habilita is only examined here, when the press is complete.
               if (habilita && cap_um_quente) begin
                  prox_estado   = PULSO;
                  valor_carrega = 1'b1;
               end else begin
                  prox_estado = DESCARTA;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         PULSO, DESCARTA: begin
            prox_estado = ESPERA_SOLTAR;
            cnt_zera    = 1'b1;
         end
         ESPERA_SOLTAR: begin
            if (s != '0) begin
               cnt_zera = 1'b1;
            end else if (cnt == CNT_FIM) begin
               prox_estado = OCIOSO;
               cnt_zera    = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            prox_estado = ESPERA_SOLTAR;
            cnt_zera    = 1'b1;
         end
      endcase
   end

   // Moore decodes of the state.
   assign jogada    = (estado == PULSO);
   assign ignorada  = (estado == DESCARTA);
   assign db_estado = estado;

`ifdef EXP5_TIMEOUT_EN
   localparam int            TW       = $clog2(TIMEOUT_CICLOS);
   localparam logic [TW-1:0] TCNT_FIM = TW'(TIMEOUT_CICLOS - 1);

   logic [TW-1:0] tcnt;

   // Idle timer: runs only while idle and enabled, and pulses timeout once per period.
   always_ff @(posedge clock) begin
      if (reset) begin
         tcnt    <= '0;
         timeout <= 1'b0;
      end else if (estado == OCIOSO && habilita) begin
         if (tcnt == TCNT_FIM) begin
            tcnt    <= '0;
            timeout <= 1'b1;
         end else begin
            tcnt    <= tcnt + TW'(1);
            timeout <= 1'b0;
         end
      end else begin
         tcnt    <= '0;
         timeout <= 1'b0;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_exp5_detector_jogada.sv
// Directed bench for exp5_detector_jogada with DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_exp5_detector_jogada;

   localparam int N   = 4;
   localparam int DEB = 4;
   localparam int TO  = 20;
`ifdef EXP5_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         clock;
   logic         reset;
   logic [N-1:0] botoes;
   logic         habilita;
   logic         jogada;
   logic [N-1:0] valor_jogada;
   logic         ignorada;
   logic         timeout;
   logic [2:0]   db_estado;

   int total = 0;
   int bad   = 0;
   int n_jog = 0;
   int n_ign = 0;
   int n_to  = 0;
   int base_jog, base_ign, base_to;

   exp5_detector_jogada #(
      .N_BOTOES       (N),
      .DEBOUNCE_CICLOS(DEB),
      .TIMEOUT_CICLOS (TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .botoes      (botoes),
      .habilita    (habilita),
      .jogada      (jogada),
      .valor_jogada(valor_jogada),
      .ignorada    (ignorada),
      .timeout     (timeout),
      .db_estado   (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse counters. They sample the settled pre-edge values on each rising edge.
   always @(posedge clock) begin
      if (jogada)   n_jog++;
      if (ignorada) n_ign++;
      if (timeout)  n_to++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic snap();
      base_jog = n_jog;
      base_ign = n_ign;
      base_to  = n_to;
   endtask

   // Expected state and strobe after edge e0+k. At e0 the new buttons are sampled.
   int st_ok  [8] = '{0, 0, 1, 1, 1, 1, 2, 4};
   int st_ign [8] = '{0, 0, 1, 1, 1, 1, 3, 4};
   int pl_ok  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
   // Expected state after release edge r+k while waiting for the release.
   int st_rel [6] = '{4, 4, 4, 4, 4, 0};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      botoes   = '0;
      habilita = 1'b0;
      cyc(2);
      check("rst_estado", db_estado, 4);
      check("rst_jogada", jogada, 0);
      check("rst_valor", valor_jogada, 0);
      check("rst_ignorada", ignorada, 0);
      check("rst_timeout", timeout, 0);
      reset = 1'b0;
      cyc(10);
      check("idle_after_rst", db_estado, 0);

      // Test 1: clean press of button 1
      habilita = 1'b1;
      botoes   = 4'b0010;
      snap();
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         check($sformatf("t1_estado_k%0d", k), db_estado, st_ok[k]);
         check($sformatf("t1_jogada_k%0d", k), jogada, pl_ok[k]);
         if (k == 6) check("t1_valor", valor_jogada, 4'b0010);
      end
      cyc(12);
      botoes = '0;
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         check($sformatf("t1_rel_k%0d", k), db_estado, st_rel[k]);
      end
      check("t1_njog", n_jog - base_jog, 1);
      check("t1_valor_held", valor_jogada, 4'b0010);
      cyc(4);

      // Test 2: bouncy press of button 2, then bouncy release
      snap();
      begin
         logic [3:0] bounce [9] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0101,
                                    4'b0100, 4'b0100, 4'b0000, 4'b0100};
         for (int i = 0; i < 9; i++) begin
            botoes = bounce[i];
            cyc(1);
         end
      end
      check("t2_no_early_jogada", n_jog - base_jog, 0);
      cyc(20);
      check("t2_njog", n_jog - base_jog, 1);
      check("t2_valor", valor_jogada, 4'b0100);
      check("t2_nign", n_ign - base_ign, 0);
      begin
         logic [3:0] rel [6] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000};
         for (int i = 0; i < 6; i++) begin
            botoes = rel[i];
            cyc(1);
         end
      end
      check("t2_still_wait", db_estado, 4);
      botoes = '0;
      cyc(10);
      check("t2_njog_after_rel", n_jog - base_jog, 1);
      check("t2_idle", db_estado, 0);

      // Test 3: two buttons together are discarded
      snap();
      botoes = 4'b0011;
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         check($sformatf("t3_estado_k%0d", k), db_estado, st_ign[k]);
         if (k == 6) check("t3_ignorada", ignorada, 1);
      end
      cyc(2);
      check("t3_nign", n_ign - base_ign, 1);
      check("t3_njog", n_jog - base_jog, 0);
      check("t3_valor_kept", valor_jogada, 4'b0100);
      botoes = '0;
      cyc(10);
      check("t3_idle", db_estado, 0);

      // Test 4: a press while not waiting is ignored until released
      snap();
      habilita = 1'b0;
      botoes   = 4'b1000;
      cyc(10);
      check("t4_nign", n_ign - base_ign, 1);
      check("t4_njog", n_jog - base_jog, 0);
      habilita = 1'b1;
      cyc(10);
      check("t4_held_estado", db_estado, 4);
      check("t4_held_njog", n_jog - base_jog, 0);
      botoes = '0;
      cyc(10);
      check("t4_idle", db_estado, 0);
      botoes = 4'b1000;
      cyc(10);
      check("t4_njog_repress", n_jog - base_jog, 1);
      check("t4_valor", valor_jogada, 4'b1000);
      botoes = '0;
      cyc(10);

      // Test 5: reset in the middle of filtering
      snap();
      botoes = 4'b0001;
      cyc(4);
      check("t5_filtra", db_estado, 1);
      reset = 1'b1;
      cyc(1);
      check("t5_rst_estado", db_estado, 4);
      check("t5_rst_valor", valor_jogada, 0);
      check("t5_rst_jogada", jogada, 0);
      reset = 1'b0;
      cyc(10);
      check("t5_held_estado", db_estado, 4);
      check("t5_njog", n_jog - base_jog, 0);
      botoes = '0;
      cyc(5);
      check("t5_rel_wait", db_estado, 4);
      cyc(1);
      check("t5_rel_idle", db_estado, 0);

      // Test 6: idle timeout. At this point OCIOSO was entered on the last edge (j=0).
      snap();
      for (int j = 1; j < 45; j++) begin
         cyc(1);
         check($sformatf("t6_timeout_j%0d", j), timeout,
               (TO_EN && (j == 20 || j == 40)) ? 1 : 0);
      end
      check("t6_nto", n_to - base_to, TO_EN ? 2 : 0);
      snap();
      botoes = 4'b0001;
      cyc(12);
      botoes = '0;
      cyc(8);
      check("t6_press_clears", n_to - base_to, 0);
      check("t6_njog", n_jog - base_jog, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
